// File: rtl/search_and_add_param.sv
// Associative search-and-add table fed by a record FIFO; dumps {key, sum} on kick.
// Define SEARCH_AND_ADD_SAT_EN to make hit updates saturate instead of wrap.
module search_and_add_param #(
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned VAL_W   = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ready,
    input  logic                   kick,
    output logic                   busy,
    input  logic [KEY_W+VAL_W-1:0] din,
    input  logic                   we,
    output logic                   full,
    output logic [31:0]            accum_addr,
    output logic [KEY_W+VAL_W-1:0] accum_din,
    output logic                   accum_we,
    output logic                   overflow
);
    localparam int unsigned DW    = KEY_W + VAL_W;
    localparam int unsigned DEPTH = 2**FIFO_AW;
    localparam int unsigned SW    = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned IW    = $clog2(ENTRIES + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOOKUP, S_UPDATE, S_DUMP} state_t;

    state_t              r_state, w_next;
    logic [DW-1:0]       r_fifo [DEPTH];
    logic [FIFO_AW:0]    r_wr_ptr, r_rd_ptr, w_count;
    logic [KEY_W-1:0]    r_key [ENTRIES];
    logic [VAL_W-1:0]    r_sum [ENTRIES];
    logic [ENTRIES-1:0]  r_valid;
    logic [IW-1:0]       r_init_idx;
    logic [SW-1:0]       r_dump_idx, r_hit_idx, r_free_idx, w_hit_idx, w_free_idx;
    logic [KEY_W-1:0]    r_hold_key;
    logic [VAL_W-1:0]    r_hold_val, w_upd_sum;
    logic [VAL_W:0]      w_sum_wide;
    logic [31:0]         r_acc_cnt, r_accum_addr;
    logic [DW-1:0]       r_accum_din;
    logic                r_ready, r_kick_pend, r_accum_we, r_overflow;
    logic                r_hit, r_free_ok, w_hit, w_free_ok;
    logic                w_empty, w_full, w_wr, w_pop, w_dump_start, w_dump_last, w_init_run;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (w_count == (FIFO_AW+1)'(DEPTH));
    assign w_wr       = we && r_ready && !w_full;
    assign w_init_run = (r_state == S_INIT) && (r_init_idx != IW'(ENTRIES));

    assign ready      = r_ready;
    assign busy       = r_kick_pend;
    assign full       = w_full;
    assign accum_addr = r_accum_addr;
    assign accum_din  = r_accum_din;
    assign accum_we   = r_accum_we;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_pop        = 1'b0;
        w_dump_start = 1'b0;
        w_dump_last  = 1'b0;
        case (r_state)
            S_INIT:   if (r_init_idx == IW'(ENTRIES)) w_next = S_IDLE;
            S_IDLE: begin
                if (r_kick_pend && w_empty) begin
                    w_next       = S_DUMP;
                    w_dump_start = 1'b1;
                end else if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: w_next = S_UPDATE;
            S_UPDATE: w_next = S_IDLE;
            S_DUMP: begin
                if (r_dump_idx == SW'(ENTRIES - 1)) begin
                    w_next      = S_IDLE;
                    w_dump_last = 1'b1;
                end
            end
            default:  w_next = S_INIT;
        endcase
    end

    // Keys are unique, so at most one slot can match; free search keeps the lowest index.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free_ok  = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_key[i] == r_hold_key)) begin
                w_hit     = 1'b1;
                w_hit_idx = SW'(i);
            end
            if (!r_valid[i] && !w_free_ok) begin
                w_free_ok  = 1'b1;
                w_free_idx = SW'(i);
            end
        end
    end

    always_comb begin
        w_sum_wide = {1'b0, r_sum[r_hit_idx]} + {1'b0, r_hold_val};
`ifdef SEARCH_AND_ADD_SAT_EN
        w_upd_sum  = w_sum_wide[VAL_W] ? '1 : w_sum_wide[VAL_W-1:0];
`else
        w_upd_sum  = w_sum_wide[VAL_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_init_idx   <= '0;
            r_ready      <= 1'b0;
            r_kick_pend  <= 1'b0;
            r_dump_idx   <= '0;
            r_acc_cnt    <= '0;
            r_accum_we   <= 1'b0;
            r_accum_addr <= '0;
            r_accum_din  <= '0;
            r_overflow   <= 1'b0;
            r_hold_key   <= '0;
            r_hold_val   <= '0;
            r_hit        <= 1'b0;
            r_hit_idx    <= '0;
            r_free_ok    <= 1'b0;
            r_free_idx   <= '0;
        end else begin
            r_accum_we <= 1'b0;
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_init_run) r_init_idx <= r_init_idx + 1'b1;
            if (r_state == S_INIT && !w_init_run) r_ready <= 1'b1;
            if (kick && r_ready && !r_kick_pend) r_kick_pend <= 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                {r_hold_key, r_hold_val} <= r_fifo[r_rd_ptr[FIFO_AW-1:0]];
            end
            if (r_state == S_LOOKUP) begin
                r_hit      <= w_hit;
                r_hit_idx  <= w_hit_idx;
                r_free_ok  <= w_free_ok;
                r_free_idx <= w_free_idx;
            end
            if (r_state == S_UPDATE && !r_hit && !r_free_ok) r_overflow <= 1'b1;
            if (w_dump_start) begin
                r_dump_idx <= '0;
                r_acc_cnt  <= '0;
            end
            if (r_state == S_DUMP) begin
                if (r_valid[r_dump_idx]) begin
                    r_accum_we   <= 1'b1;
                    r_accum_addr <= r_acc_cnt;
                    r_accum_din  <= {r_key[r_dump_idx], r_sum[r_dump_idx]};
                    r_acc_cnt    <= r_acc_cnt + 32'd1;
                end
                r_dump_idx <= r_dump_idx + 1'b1;
                // Placed last so a kick landing on the final slot cannot re-arm the dump.
                if (w_dump_last) begin
                    r_kick_pend <= 1'b0;
                    r_overflow  <= 1'b0;
                end
            end
        end
    end

    // Storage is not reset; INIT clears the valid bits before any traffic is accepted.
    always_ff @(posedge clk) begin
        if (w_wr) r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= din;
        if (w_init_run) r_valid[SW'(r_init_idx)] <= 1'b0;
        if (r_state == S_UPDATE) begin
            if (r_hit) begin
                r_sum[r_hit_idx] <= w_upd_sum;
            end else if (r_free_ok) begin
                r_key[r_free_idx]   <= r_hold_key;
                r_sum[r_free_idx]   <= r_hold_val;
                r_valid[r_free_idx] <= 1'b1;
            end
        end
        if (r_state == S_DUMP) r_valid[r_dump_idx] <= 1'b0;
    end
endmodule

// File: tb/tb_search_and_add_param.sv
// Directed bench: one default-sized instance and one with ENTRIES=4, FIFO_AW=2.
module tb_search_and_add_param;
    localparam int KW = 128;
    localparam int VW = 32;
    localparam int DW = KW + VW;
`ifdef SEARCH_AND_ADD_SAT_EN
    localparam logic [VW-1:0] EXP_WRAP_SUM = 32'hFFFFFFFF;
`else
    localparam logic [VW-1:0] EXP_WRAP_SUM = 32'h00000010;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          a_kick = 1'b0, a_we = 1'b0;
    logic [DW-1:0] a_din = '0;
    logic          a_ready, a_busy, a_full, a_accum_we, a_overflow;
    logic [31:0]   a_accum_addr;
    logic [DW-1:0] a_accum_din;

    logic          b_kick = 1'b0, b_we = 1'b0;
    logic [DW-1:0] b_din = '0;
    logic          b_ready, b_busy, b_full, b_accum_we, b_overflow;
    logic [31:0]   b_accum_addr;
    logic [DW-1:0] b_accum_din;

    search_and_add_param u_a (
        .clk(clk), .reset(reset), .ready(a_ready), .kick(a_kick), .busy(a_busy),
        .din(a_din), .we(a_we), .full(a_full), .accum_addr(a_accum_addr),
        .accum_din(a_accum_din), .accum_we(a_accum_we), .overflow(a_overflow)
    );

    search_and_add_param #(.ENTRIES(4), .FIFO_AW(2)) u_b (
        .clk(clk), .reset(reset), .ready(b_ready), .kick(b_kick), .busy(b_busy),
        .din(b_din), .we(b_we), .full(b_full), .accum_addr(b_accum_addr),
        .accum_din(b_accum_din), .accum_we(b_accum_we), .overflow(b_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0]   q_addr[$];
    logic [DW-1:0] q_din[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [KW-1:0] key_of(input int n);
        return {96'hC0DE0000_00000000_00000000, 32'(n)};
    endfunction

    task automatic put(input bit sel, input logic [KW-1:0] k, input logic [VW-1:0] v);
        if (sel) begin b_din = {k, v}; b_we = 1'b1; end
        else     begin a_din = {k, v}; a_we = 1'b1; end
        @(negedge clk);
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic pulse_kick(input bit sel);
        if (sel) b_kick = 1'b1; else a_kick = 1'b1;
        @(negedge clk);
        a_kick = 1'b0;
        b_kick = 1'b0;
    endtask

    // Kick, then record every strobe until busy falls (the final strobe shares that cycle).
    task automatic dump(input bit sel, output int busy_cyc);
        logic done;
        done     = 1'b0;
        busy_cyc = 0;
        q_addr.delete();
        q_din.delete();
        pulse_kick(sel);
        for (int c = 0; c < 600; c++) begin
            if (sel ? b_accum_we : a_accum_we) begin
                q_addr.push_back(sel ? b_accum_addr : a_accum_addr);
                q_din.push_back(sel ? b_accum_din : a_accum_din);
            end
            if (sel ? b_busy : a_busy) busy_cyc++;
            else begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("dump_done", done, 1);
    endtask

    initial begin
        int bc, a_rdy_at, b_rdy_at, strobes, total;
        logic full_seen, got2;
        logic [KW-1:0] key_a, key_b;
        key_a = 128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434;
        key_b = 128'h01234567_89ABCDEF_00112233_44556677;

        // Reset values
        @(negedge clk);
        check("rst_ready", a_ready, 0);
        check("rst_busy", a_busy, 0);
        check("rst_full", a_full, 0);
        check("rst_accum_we", a_accum_we, 0);
        check("rst_overflow", a_overflow, 0);
        check("rst_accum_addr", a_accum_addr, 0);
        check("rst_accum_din", a_accum_din, 0);

        // INIT length; writes during INIT must be ignored
        @(negedge clk);
        reset = 1'b1;
        a_din = {key_of(99), 32'd77}; a_we = 1'b1;
        b_din = {key_of(99), 32'd77}; b_we = 1'b1;
        a_rdy_at = 0; b_rdy_at = 0; full_seen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 4)  b_we = 1'b0;
            if (c == 10) a_we = 1'b0;
            if (a_ready && a_rdy_at == 0) a_rdy_at = c;
            if (b_ready && b_rdy_at == 0) b_rdy_at = c;
            if (a_full || b_full) full_seen = 1'b1;
        end
        check("init_cycles_a", a_rdy_at, 17);
        check("init_cycles_b", b_rdy_at, 5);
        check("init_full", full_seen, 0);

        // Hit accumulation
        put(0, key_a, 32'h5A5A5A5A);
        put(0, key_a, 32'h5A5A5A5A);
        dump(0, bc);
        check("hit_nrec", q_din.size(), 1);
        check("hit_addr", q_addr[0], 0);
        check("hit_din", q_din[0], {key_a, 32'hB4B4B4B4});
        check("hit_busy_after", a_busy, 0);
        check("hit_overflow", a_overflow, 0);

        // Sum overflow on hit: wrap or saturate
        put(0, key_b, 32'hFFFFFFF0);
        put(0, key_b, 32'h00000020);
        dump(0, bc);
        check("wrap_nrec", q_din.size(), 1);
        check("wrap_din", q_din[0], {key_b, EXP_WRAP_SUM});

        // Table full on the small instance
        for (int i = 0; i < 5; i++) put(1, key_of(i), 32'(i + 1));
        repeat (25) @(negedge clk);
        check("ovf_before", b_overflow, 1);
        dump(1, bc);
        check("ovf_nrec", q_din.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_addr%0d", i), q_addr[i], i);
            check($sformatf("ovf_din%0d", i), q_din[i], {key_of(i), 32'(i + 1)});
        end
        check("ovf_after", b_overflow, 0);

        // FIFO full while an (empty) dump holds off processing; accepted: 0,1,2,3,6,9
        pulse_kick(1);
        for (int i = 0; i < 12; i++) begin
            b_din = {key_of(100 + (i % 2)), 32'(1 << i)};
            b_we  = 1'b1;
            @(negedge clk);
            if (i == 2) check("fifo_full_3rd", b_full, 0);
            if (i == 3) check("fifo_full_4th", b_full, 1);
        end
        b_we = 1'b0;
        repeat (40) @(negedge clk);
        dump(1, bc);
        check("fifo_nrec", q_din.size(), 2);
        check("fifo_din0", q_din[0], {key_of(100), 32'h45});
        check("fifo_din1", q_din[1], {key_of(101), 32'h20A});
        total = 0;
        foreach (q_din[i]) total += int'(q_din[i][VW-1:0]);
        check("fifo_total", total, 591);

        // Reset in the middle of a dump
        for (int i = 0; i < 4; i++) put(1, key_of(200 + i), 32'(11 + i));
        repeat (20) @(negedge clk);
        pulse_kick(1);
        strobes = 0; got2 = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (b_accum_we) strobes++;
            if (strobes == 2) begin
                got2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_two_strobes", got2, 1);
        reset = 1'b0;
        #1;
        check("mid_accum_we", b_accum_we, 0);
        check("mid_busy", b_busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 40 && !(a_ready && b_ready); c++) @(negedge clk);
        check("mid_ready", a_ready & b_ready, 1);
        dump(1, bc);
        check("mid_empty_busy_b", bc, 5);
        check("mid_empty_nrec_b", q_din.size(), 0);
        dump(0, bc);
        check("mid_empty_busy_a", bc, 17);
        check("mid_empty_nrec_a", q_din.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/search_and_add_param.md
Name: search_and_add_param

Overview:
Parametrised successor to the word-count search-and-add stage. It accepts {key, value} records through a write-only FIFO port and looks each key up in an internal associative table of ENTRIES slots. On a hit it adds the value to the stored sum; on a miss it allocates a new slot. On kick, it streams every valid slot to the accumulator-memory port and then clears the table. It sits between the tokeniser front end and the result memory.

Parameters:
KEY_W, 128, key width in bits
VAL_W, 32, value/sum width in bits
ENTRIES, 16, table slots (1..64)
FIFO_AW, 4, log2 of input FIFO depth (depth = 2**FIFO_AW)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
ready  out  1  table initialised; block accepts traffic
kick  in  1  single-cycle pulse; request dump and clear
busy  out  1  dump pending or in progress
din  in  KEY_W+VAL_W  record: key in upper KEY_W bits, value in lower VAL_W bits
we  in  1  write din into FIFO
full  out  1  FIFO full; writes while full are dropped
accum_addr  out  32  output sequence index of the dumped slot
accum_din  out  KEY_W+VAL_W  dumped record {key, sum}
accum_we  out  1  accum_addr/accum_din valid this cycle
overflow  out  1  sticky: a miss found the table full; record discarded

Behaviour:
- Reset (reset=0, asynchronous):
  - ready, busy, full, accum_we, overflow = 0.
  - accum_addr and accum_din = 0.
  - FIFO pointers = 0, kick-pending = 0, FSM = INIT, init index = 0.
- INIT:
  - Clears one slot's valid bit per cycle for ENTRIES cycles.
  - ready rises the cycle after the last slot is cleared, then FSM goes to IDLE.
  - we is ignored while ready=0.
- FIFO behaviour:
  - The FIFO has 2**FIFO_AW entries. full = (count == depth).
  - A write with we=1 and full=0 is stored. A write while full is dropped with no other side effect.
  - Simultaneous write and read while full: the write is still dropped, because full is evaluated before the read.
- Record processing FSM (one record per 3 cycles):
  - IDLE: if kick-pending and FIFO empty, go to DUMP. Otherwise, if FIFO not empty, pop the head into a holding register and go to LOOKUP.
  - LOOKUP: compare the held key against all valid slots in parallel. Register hit, hit index, and the lowest free index. Go to UPDATE.
  - UPDATE, hit: sum[hit] <= sum[hit] + value, modulo 2**VAL_W unless SAT is enabled.
  - UPDATE, miss with a free slot: write {key, value} into the lowest free slot and set valid.
  - UPDATE, miss with no free slot: discard the record and set overflow=1.
  - UPDATE always returns to IDLE.
  - Keys are unique in the table, so at most one hit is possible.
- Kick and dump:
  - kick with ready=1 and busy=0 sets kick-pending and raises busy the next cycle.
  - kick while busy=1 or ready=0 is ignored.
  - Records already in the FIFO at kick are drained before DUMP starts. Records written during DUMP stay queued and are processed after it.
  - DUMP scans slots 0..ENTRIES-1, one slot per cycle.
  - For each valid slot: accum_we=1, accum_din={key, sum}, accum_addr = running count starting at 0. The slot's valid bit is cleared in the same cycle.
  - Invalid slots produce accum_we=0.
  - After the last slot: busy=0, kick-pending=0, FSM returns to IDLE.
  - Dump length is always ENTRIES cycles. An empty table gives busy high for ENTRIES+1 cycles and no accum_we.
  - overflow is cleared when a dump completes.
- accum_we is a single-cycle strobe. accum_addr/accum_din hold their last value when accum_we=0.
- Reset asserted mid-operation: everything aborts immediately, accum_we drops asynchronously, and INIT reruns. No partial dump resumes.

Optional Feature:
SEARCH_AND_ADD_SAT_EN
- Defined: the UPDATE-hit sum saturates at 2**VAL_W-1.
- Undefined: the sum wraps modulo 2**VAL_W.
- The miss path is unaffected either way.

Test Plan:
- Reset, then count cycles from reset release until ready=1 -> exactly ENTRIES+1 cycles (17 with defaults); ready stays 0 and full stays 0 throughout.
- Write {128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434, 32'h5A5A5A5A} twice, then kick -> one accum_we with accum_addr=0, accum_din={same key, 32'hB4B4B4B4}; busy falls and overflow=0.
- Write key A with value 32'hFFFFFFF0, then key A with value 32'h20, then kick -> sum 32'hFFFFFFFF with SEARCH_AND_ADD_SAT_EN defined, 32'h00000010 without it.
- With ENTRIES=4, write 5 distinct keys (values 1..5), then kick -> 4 accum_we with accum_addr 0..3 and values 1..4; overflow=1 before the dump and 0 after.
- With FIFO_AW=2, write 12 back-to-back records -> full=1 after the 4th accepted record; the dropped records never appear in the dump; the total of dumped sums equals the sum of accepted values.
- Assert reset low mid-DUMP after 2 strobes -> accum_we=0 and busy=0 immediately; after INIT, kick -> busy high for ENTRIES+1 cycles and zero accum_we.
